// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write side.
// A write record carries its own valid bit so queued writes can be cancelled in place.
package rf_pkg;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 2 ** AW;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_rec_t;

    function automatic logic [NREG-1:0] addr_onehot(input logic [AW-1:0] a);
        addr_onehot    = '0;
        addr_onehot[a] = 1'b1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// WB-stage, late-writer and regfile write-port signals of the write arbiter.
// The master side is the pipeline/late writer; the slave side is the arbiter.
interface regfile_write_arbiter_if;
    import rf_pkg::*;

    logic              wbe;
    logic [AW-1:0]     wba;
    logic [DW-1:0]     wbd;
    logic              lvalid;
    logic              lready;
    logic [AW-1:0]     laddr;
    logic [DW-1:0]     ldata;
    logic              we3;
    logic [AW-1:0]     ra3;
    logic [DW-1:0]     wd3;
    logic [NREG-1:0]   busy;
    logic              hold;
    logic              empty;

    modport master (
        output wbe, wba, wbd, lvalid, laddr, ldata,
        input  lready, we3, ra3, wd3, busy, hold, empty
    );

    modport slave (
        input  wbe, wba, wbd, lvalid, laddr, ldata,
        output lready, we3, ra3, wd3, busy, hold, empty
    );

endinterface

// File: rtl/rf_late_fifo.sv
// Late-write queue: DEPTH entries with per-entry valid, address-match cancel,
// and a per-entry one-hot address decode feeding the BUSY vector.
module rf_late_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [AW-1:0]               push_addr,
    input  logic [DW-1:0]               push_data,
    input  logic                        pop,
    input  logic                        cancel,
    input  logic [AW-1:0]               cancel_addr,
    output wr_rec_t                     head,
    output logic                        full,
    output logic                        empty,
    output logic [DEPTH-1:0][NREG-1:0]  entry_dec
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]  addr_reg [DEPTH];
    logic [DW-1:0]  data_reg [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [PW:0]    count_reg;

    // Count top bit set means exactly DEPTH entries held.
    assign full  = count_reg[PW];
    assign empty = (count_reg == '0);
    assign head  = '{valid: valid_reg[rd_ptr_reg],
                     addr:  addr_reg[rd_ptr_reg],
                     data:  data_reg[rd_ptr_reg]};

    always_ff @(posedge clk) begin
        if (push) begin
            addr_reg[wr_ptr_reg] <= push_addr;
            data_reg[wr_ptr_reg] <= push_data;
        end
    end

    // The push slot is always free, so a same-cycle cancel can never hit it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cancel && valid_reg[i] && (addr_reg[i] == cancel_addr))
                    valid_reg[i] <= 1'b0;
            end
            if (pop)
                valid_reg[rd_ptr_reg] <= 1'b0;
            if (push)
                valid_reg[wr_ptr_reg] <= 1'b1;
            wr_ptr_reg <= wr_ptr_reg + PW'(push);
            rd_ptr_reg <= rd_ptr_reg + PW'(pop);
            count_reg  <= count_reg + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dec
        assign entry_dec[gi] = valid_reg[gi] ? addr_onehot(addr_reg[gi]) : '0;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges in-order WB writes and queued late writes onto the single regfile
// write port; WB always wins, a starve counter asks for a WB bubble via HOLD.
module regfile_write_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  bus
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    wr_rec_t                    head;
    logic                       full;
    logic                       empty;
    logic [DEPTH-1:0][NREG-1:0] entry_dec;

    logic            wb_issue;
    logic            head_valid;
    logic            late_issue;
    logic            pop;
    logic            push;
    logic            we3_reg;
    logic [AW-1:0]   ra3_reg;
    logic [DW-1:0]   wd3_reg;
    logic            hold_reg;
    logic [CW-1:0]   starve_reg;
    logic [CW-1:0]   starve_next;
    logic [NREG-1:0] busy_vec;

    assign wb_issue   = bus.wbe && (bus.wba != REG_ZERO);
    assign head_valid = !empty && head.valid;
    assign late_issue = head_valid && !wb_issue;
    // A cancelled head is dropped even while WB owns the port.
    assign pop        = !empty && (!head.valid || !wb_issue);
    // Writes to r0 complete the handshake but are never stored.
    assign push       = bus.lvalid && !full && (bus.laddr != REG_ZERO);

    rf_late_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_addr   (bus.laddr),
        .push_data   (bus.ldata),
        .pop         (pop),
        .cancel      (wb_issue),
        .cancel_addr (bus.wba),
        .head        (head),
        .full        (full),
        .empty       (empty),
        .entry_dec   (entry_dec)
    );

    always_comb begin
        starve_next = starve_reg;
        if (empty || late_issue)
            starve_next = '0;
        else if (head_valid && (starve_reg != CW'(STARVE_LIMIT)))
            starve_next = starve_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3_reg    <= 1'b0;
            ra3_reg    <= '0;
            wd3_reg    <= '0;
            hold_reg   <= 1'b0;
            starve_reg <= '0;
        end else begin
            starve_reg <= starve_next;
            hold_reg   <= (starve_next == CW'(STARVE_LIMIT));
            we3_reg    <= wb_issue || late_issue;
            if (wb_issue) begin
                ra3_reg <= bus.wba;
                wd3_reg <= bus.wbd;
            end else if (late_issue) begin
                ra3_reg <= head.addr;
                wd3_reg <= head.data;
            end
        end
    end

    always_comb begin
        busy_vec = we3_reg ? addr_onehot(ra3_reg) : '0;
        for (int i = 0; i < DEPTH; i++)
            busy_vec = busy_vec | entry_dec[i];
        busy_vec[0] = 1'b0;
    end

    assign bus.lready = !full;
    assign bus.empty  = empty;
    assign bus.we3    = we3_reg;
    assign bus.ra3    = ra3_reg;
    assign bus.wd3    = wd3_reg;
    assign bus.hold   = hold_reg;
    assign bus.busy   = busy_vec;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected regfile writes go into a
// scoreboard queue and are popped whenever WE3 is seen.
module tb_regfile_write_arbiter;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        sb.push_back('{a: a, d: d});
    endtask

    task automatic idle();
        bus.wbe    = 1'b0;
        bus.lvalid = 1'b0;
    endtask

    // Scoreboard monitor: every regfile write must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.we3 === 1'b1) begin
            $display("write r%0d = %08h", bus.ra3, bus.wd3);
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write observed=r%0d/%0h expected=none", bus.ra3, bus.wd3);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("wr_addr", 64'(bus.ra3), 64'(mon_e.a));
                chk("wr_data", 64'(bus.wd3), 64'(mon_e.d));
            end
        end
    end

    initial begin
        idle();
        bus.wba   = '0;
        bus.wbd   = '0;
        bus.laddr = '0;
        bus.ldata = '0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_we3",    64'(bus.we3),    64'd0);
        chk("rst_ra3",    64'(bus.ra3),    64'd0);
        chk("rst_wd3",    64'(bus.wd3),    64'd0);
        chk("rst_empty",  64'(bus.empty),  64'd1);
        chk("rst_lready", 64'(bus.lready), 64'd1);
        chk("rst_busy",   64'(bus.busy),   64'd0);
        chk("rst_hold",   64'(bus.hold),   64'd0);
        step();
        rst = 1'b0;
        step();

        // Late write into an idle pipeline: WE3 two cycles after acceptance
        bus.lvalid = 1'b1; bus.laddr = 5'd5; bus.ldata = 32'hDEADBEEF;
        chk("late_lready", 64'(bus.lready), 64'd1);
        expect_wr(5'd5, 32'hDEADBEEF);
        step(); idle();
        chk("late_c1_busy5", 64'(bus.busy[5]), 64'd1);
        chk("late_c1_we3",   64'(bus.we3),     64'd0);
        step();
        chk("late_c2_we3",   64'(bus.we3),     64'd1);
        chk("late_c2_ra3",   64'(bus.ra3),     64'd5);
        chk("late_c2_wd3",   64'(bus.wd3),     64'hDEADBEEF);
        chk("late_c2_busy5", 64'(bus.busy[5]), 64'd1);
        chk("late_c2_empty", 64'(bus.empty),   64'd1);
        step();
        chk("late_c3_busy5", 64'(bus.busy[5]), 64'd0);
        chk("late_c3_we3",   64'(bus.we3),     64'd0);

        // Priority and fill: WB 3,4 win; queue fills with 7,8; 9 waits
        bus.wbe = 1'b1; bus.wba = 5'd3; bus.wbd = 32'h33;
        bus.lvalid = 1'b1; bus.laddr = 5'd7; bus.ldata = 32'h77;
        expect_wr(5'd3, 32'h33);
        step();
        bus.wba = 5'd4; bus.wbd = 32'h44;
        bus.laddr = 5'd8; bus.ldata = 32'h88;
        expect_wr(5'd4, 32'h44);
        step();
        bus.wbe = 1'b0;
        bus.laddr = 5'd9; bus.ldata = 32'h99;
        chk("fill_lready_full", 64'(bus.lready), 64'd0);
        chk("fill_busy7",       64'(bus.busy[7]), 64'd1);
        expect_wr(5'd7, 32'h77);
        expect_wr(5'd8, 32'h88);
        step();
        chk("fill_lready_free", 64'(bus.lready), 64'd1);
        expect_wr(5'd9, 32'h99);
        step(); idle();
        step(); step();
        chk("fill_empty",   64'(bus.empty),  64'd1);
        chk("fill_drained", 64'(sb.size()),  64'd0);

        // Cancellation: WB write to r6 supersedes queued late write to r6
        bus.wbe = 1'b1; bus.wba = 5'd1; bus.wbd = 32'hA1;
        bus.lvalid = 1'b1; bus.laddr = 5'd6; bus.ldata = 32'h11;
        expect_wr(5'd1, 32'hA1);
        step();
        bus.lvalid = 1'b0;
        bus.wba = 5'd6; bus.wbd = 32'h22;
        chk("cancel_busy6_queued", 64'(bus.busy[6]), 64'd1);
        expect_wr(5'd6, 32'h22);
        step();
        bus.wbe = 1'b0;
        chk("cancel_slot_kept",   64'(bus.empty),   64'd0);
        chk("cancel_busy6_wr",    64'(bus.busy[6]), 64'd1);
        step();
        chk("cancel_busy6_clear", 64'(bus.busy[6]), 64'd0);
        chk("cancel_empty",       64'(bus.empty),   64'd1);
        chk("cancel_no_write",    64'(bus.we3),     64'd0);

        // Starvation: head blocked for 4 cycles raises HOLD
        bus.wbe = 1'b1; bus.wba = 5'd1; bus.wbd = 32'hB0;
        bus.lvalid = 1'b1; bus.laddr = 5'd10; bus.ldata = 32'hAA;
        expect_wr(5'd1, 32'hB0);
        step();
        bus.lvalid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            bus.wbd = 32'hB0 + 32'(k);
            expect_wr(5'd1, 32'hB0 + 32'(k));
            if (k == 4)
                chk("starve_hold_early", 64'(bus.hold), 64'd0);
            step();
        end
        chk("starve_hold_set", 64'(bus.hold), 64'd1);
        bus.wbe = 1'b0;
        expect_wr(5'd10, 32'hAA);
        step();
        chk("starve_head_we3", 64'(bus.we3),  64'd1);
        chk("starve_head_ra3", 64'(bus.ra3),  64'd10);
        chk("starve_hold_clr", 64'(bus.hold), 64'd0);
        step();
        chk("starve_hold_low",  64'(bus.hold),  64'd0);
        chk("starve_empty",     64'(bus.empty), 64'd1);

        // Register 0: neither source produces a write
        bus.wbe = 1'b1; bus.wba = 5'd0; bus.wbd = 32'hFF;
        bus.lvalid = 1'b1; bus.laddr = 5'd0; bus.ldata = 32'h55;
        chk("r0_lready", 64'(bus.lready), 64'd1);
        step(); idle();
        chk("r0_we3",   64'(bus.we3),     64'd0);
        chk("r0_empty", 64'(bus.empty),   64'd1);
        chk("r0_busy0", 64'(bus.busy[0]), 64'd0);
        step();
        chk("r0_we3_late", 64'(bus.we3), 64'd0);

        // Reset mid-traffic with two queued entries
        bus.wbe = 1'b1; bus.wba = 5'd2; bus.wbd = 32'hC2;
        bus.lvalid = 1'b1; bus.laddr = 5'd11; bus.ldata = 32'h1B;
        expect_wr(5'd2, 32'hC2);
        step();
        bus.wba = 5'd3; bus.wbd = 32'hC3;
        bus.laddr = 5'd12; bus.ldata = 32'h1C;
        step(); idle();
        chk("mid_queued_full", 64'(bus.lready), 64'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_we3",    64'(bus.we3),    64'd0);
        chk("mid_rst_empty",  64'(bus.empty),  64'd1);
        chk("mid_rst_busy",   64'(bus.busy),   64'd0);
        chk("mid_rst_lready", 64'(bus.lready), 64'd1);
        chk("mid_rst_hold",   64'(bus.hold),   64'd0);
        step();
        rst = 1'b0;
        repeat (6) step();
        chk("mid_post_we3",  64'(bus.we3),   64'd0);
        chk("mid_post_sb",   64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
